// File: rtl/add_pkg.sv
// Shared definitions for the chunked multi-word adder: FSM encoding and default geometry.
package add_pkg;

    localparam int N_DEF     = 8;
    localparam int WORDS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ripple_carry.sv
// N-bit combinational ripple-carry adder; the single adder shared across all chunks.
module ripple_carry #(
    parameter int N = 8
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         c,
    output logic [N-1:0] sum,
    output logic         c_out
);

    logic [N:0] cy;

    assign cy[0] = c;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i]  = A[i] ^ B[i] ^ cy[i];
        assign cy[i+1] = (A[i] & B[i]) | (cy[i] & (A[i] ^ B[i]));
    end

    assign c_out = cy[N];

endmodule

// File: rtl/multiword_add_ctrl.sv
// Sequential N*WORDS-bit adder: one N-bit ripple adder walks the chunks LSB first, one per cycle.
module multiword_add_ctrl
    import add_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N*WORDS-1:0] a_in,
    input  logic [N*WORDS-1:0] b_in,
    input  logic               cin,
    output logic               busy,
    output logic               done,
    output logic [N*WORDS-1:0] result,
    output logic               cout
);

    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    state_e                     state_q;
    logic [IDX_W-1:0]           idx_q;
    logic [IDX_W-1:0]           idx_d;
    logic                       carry_q;
    logic [WORDS-1:0][N-1:0]    a_q;
    logic [WORDS-1:0][N-1:0]    b_q;
    logic [WORDS-1:0][N-1:0]    res_q;
    logic                       cout_q;
    logic                       busy_q;
    logic                       done_q;

    logic [N-1:0]               sum;
    logic                       c_out;

    ripple_carry #(.N(N)) u_rca (
        .A     (a_q[idx_q]),
        .B     (b_q[idx_q]),
        .c     (carry_q),
        .sum   (sum),
        .c_out (c_out)
    );

    assign idx_d = idx_q + IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        carry_q <= cin;
                        idx_q   <= '0;
                        res_q   <= '0;
                        cout_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q[idx_q] <= sum;
                    carry_q      <= c_out;
                    // Park idx at 0 on the final chunk so it never leaves 0..WORDS-1.
                    if (idx_q == IDX_LAST) begin
                        idx_q   <= '0;
                        cout_q  <= c_out;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_d;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = res_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Scoreboard bench: stimulus pushes expected {cout,result}; a monitor pops on every done pulse.
module tb_multiword_add_ctrl;

    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;

    int vectors = 0;
    int miscompares = 0;
    int pushed = 0;
    int done_cnt = 0;
    logic [W:0] exp_q[$];
    logic [W:0] mon_e;

    multiword_add_ctrl #(.N(N), .WORDS(WORDS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        return {1'b0, a} + {1'b0, b} + (W+1)'(ci);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            done_cnt++;
            chk("done_matches_request", done_cnt, pushed);
            chk("busy_low_in_done", busy, 0);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("result", result, mon_e[W-1:0]);
                chk("cout", cout, mon_e[W]);
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input bit noise);
        int  k;
        bit  seen;
        @(negedge clk);
        a_in = a; b_in = b; cin = ci; start = 1'b1;
        exp_q.push_back(model(a, b, ci));
        pushed++;
        seen = 1'b0;
        for (k = 0; k < 3 * WORDS; k++) begin
            @(negedge clk);
            if (k == 0) chk("busy_in_run", busy, 1);
            start = noise;
            if (noise) begin
                a_in = $urandom; b_in = $urandom; cin = 1'($urandom_range(0, 1));
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_latency", seen ? k : -1, WORDS);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_hold(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        repeat (2) @(negedge clk);
        chk("hold_in_idle", {cout, result}, model(a, b, ci));
        chk("idle_busy", {busy, done}, 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #10;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);
        chk("reset_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'h0000_00CA, 32'h0000_00AE, 1'b0, 1'b0);
        check_hold(32'h0000_00CA, 32'h0000_00AE, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        check_hold(32'h8000_0000, 32'h8000_0000, 1'b0);

        // start re-pulsed with scrambled operands throughout RUN and DONE, then back-to-back op
        run_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b1);
        run_op(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 1'b0);

        // reset in the 2nd RUN cycle aborts with no done pulse
        @(negedge clk);
        a_in = 32'hA5A5_A5A5; b_in = 32'h0101_0101; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("partial_chunk0", result[7:0], 8'hA6);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("no_done_after_abort", done_cnt, pushed);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("total_done", done_cnt, pushed);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multiword_add_ctrl.md
MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

Interface
REQ-001 Parameter N, default 8, chunk width in bits; this is the width of the shared ripple_carry adder.
REQ-002 Parameter WORDS, default 4, number of chunks per operand; WORDS >= 2.
REQ-003 clk  input  1  Single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  Asynchronous, active-low reset.
REQ-005 start  input  1  Request to add; sampled only in IDLE.
REQ-006 a_in  input  N*WORDS  Operand A; sampled on the accepting edge.
REQ-007 b_in  input  N*WORDS  Operand B; sampled on the accepting edge.
REQ-008 cin  input  1  Carry into chunk 0; sampled on the accepting edge.
REQ-009 busy  output  1  High while in RUN.
REQ-010 done  output  1  One-cycle pulse when the result is complete.
REQ-011 result  output  N*WORDS  Registered sum.
REQ-012 cout  output  1  Registered carry out of the top chunk.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 In IDLE with start=1 at edge E0, the block SHALL latch a_in, b_in and cin, clear the chunk index to 0, clear result and cout to 0, and enter RUN.
REQ-015 In RUN, the adder SHALL be driven with chunk[idx] of A, chunk[idx] of B and carry_reg, where chunk k is bits [k*N+N-1 : k*N].
REQ-016 At each RUN edge, the block SHALL write the adder sum into result chunk[idx], load carry_reg with the adder c_out, and increment idx.
REQ-017 On the edge that writes chunk WORDS-1 (edge E0+WORDS), the block SHALL load cout from the adder c_out and enter DONE.
REQ-018 done SHALL be 1 only in DONE, exactly one cycle; DONE SHALL return to IDLE unconditionally on the next edge.
REQ-019 Latency: start accepted at E0 -> done high during the cycle following edge E0+WORDS.
REQ-020 start SHALL be ignored in RUN and DONE; no queuing, and the in-flight operation is unaffected.
REQ-021 result and cout SHALL hold their values from DONE through IDLE until the next accepted start.
REQ-022 a_in, b_in and cin changes after the accepting edge SHALL NOT affect the operation in flight.
REQ-023 Arithmetic SHALL be unsigned modulo 2^(N*WORDS), with the overflow reported on cout.
REQ-024 idx SHALL be clog2(WORDS) bits wide and SHALL never exceed WORDS-1 while in RUN.

Reset
REQ-025 On rst_n=0, immediately and independent of clk, the block SHALL enter IDLE and clear idx, carry_reg, operand registers, result, cout, busy and done to 0.
REQ-026 A reset asserted mid-RUN SHALL abort the operation, with no done pulse.
REQ-027 After rst_n deasserts, the first start in IDLE SHALL be accepted normally.

Structure
REQ-028 The state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default N and WORDS SHALL live in the shared package add_pkg.
REQ-029 The block SHALL instantiate exactly one sub-module, ripple_carry #(N), using ports A, B, c, sum and c_out; no other adder logic is permitted.
REQ-030 The adder path SHALL be combinational within one cycle; all outputs SHALL be driven from registers.

Verification (N=8, WORDS=4)
REQ-031 a_in=0x000000CA, b_in=0x000000AE, cin=0, start -> done on the 4th cycle after acceptance; result=0x00000178, cout=0.
REQ-032 a_in=0xFFFFFFFF, b_in=0x00000001, cin=0 -> result=0x00000000, cout=1 (carry ripples through all chunks).
REQ-033 a_in=0, b_in=0, cin=1 -> result=0x00000001, cout=0; then a_in=0x80000000, b_in=0x80000000 -> result=0, cout=1.
REQ-034 start re-pulsed with new operands during RUN and during DONE -> ignored; the first result is unchanged; busy is low in DONE; a start in the following IDLE cycle is accepted.
REQ-035 rst_n pulsed low during the 2nd RUN cycle -> busy=0, result=0 and cout=0 immediately; no done pulse; a subsequent 0x12345678+0x11111111 gives 0x23456789, cout=0.
